// File: rtl/alu_md_sequencer_if.sv
// EX-stage bundle between the controller/forwarding mux and the ALU control + M-extension sequencer.
// Master drives decode fields and operands; slave returns Operation and the multiply/divide handshake.
interface alu_md_sequencer_if #(
    parameter int WIDTH = 32,
    parameter int OP_W  = 4
);
    logic [1:0]       ALUOp;
    logic [6:0]       Funct7;
    logic [2:0]       Funct3;
    logic             valid_in;
    logic             flush;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic [OP_W-1:0]  Operation;
    logic             md_busy;
    logic             md_done;
    logic [WIDTH-1:0] md_result;

    modport master (
        output ALUOp, Funct7, Funct3, valid_in, flush, SrcA, SrcB,
        input  Operation, md_busy, md_done, md_result
    );

    modport slave (
        input  ALUOp, Funct7, Funct3, valid_in, flush, SrcA, SrcB,
        output Operation, md_busy, md_done, md_result
    );
endinterface

// File: rtl/alu_md_sequencer.sv
// ALU operation decode plus iterative RV32M shift-add multiplier / restoring divider.
// M ops: done WIDTH+1 cycles after accept (1 for div-by-zero/overflow); md_busy stalls EX meanwhile.
module alu_md_sequencer #(
    parameter int WIDTH = 32,
    parameter int OP_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    alu_md_sequencer_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [OP_W-1:0] OP_AND  = OP_W'(4'b0000);
    localparam logic [OP_W-1:0] OP_SUB  = OP_W'(4'b0001);
    localparam logic [OP_W-1:0] OP_ADD  = OP_W'(4'b0010);
    localparam logic [OP_W-1:0] OP_SLL  = OP_W'(4'b0011);
    localparam logic [OP_W-1:0] OP_SRL  = OP_W'(4'b0100);
    localparam logic [OP_W-1:0] OP_SRA  = OP_W'(4'b0101);
    localparam logic [OP_W-1:0] OP_XOR  = OP_W'(4'b0110);
    localparam logic [OP_W-1:0] OP_OR   = OP_W'(4'b0111);
    localparam logic [OP_W-1:0] OP_SLT  = OP_W'(4'b1000);
    localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(4'b1001);
    localparam logic [OP_W-1:0] OP_BNE  = OP_W'(4'b1010);
    localparam logic [OP_W-1:0] OP_BLT  = OP_W'(4'b1011);
    localparam logic [OP_W-1:0] OP_BGE  = OP_W'(4'b1100);
    localparam logic [OP_W-1:0] OP_SLTU = OP_W'(4'b1101);
    localparam logic [OP_W-1:0] OP_BLTU = OP_W'(4'b1110);
    localparam logic [OP_W-1:0] OP_BGEU = OP_W'(4'b1111);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t           r_state, w_state_n;
    logic [CNT_W-1:0] r_cnt, w_cnt_n;
    logic [WIDTH-1:0] r_hi, r_lo, r_b, r_result;
    logic [WIDTH-1:0] w_hi_n, w_lo_n, w_b_n, w_res_n;
    logic             r_neg_q, r_neg_r, w_neg_q_n, w_neg_r_n;
    logic [1:0]       r_op, w_op_n;

    logic             w_is_m, w_accept, w_a_sgn, w_b_sgn, w_a_neg, w_b_neg, w_div0, w_ovf, w_ge;
    logic [WIDTH-1:0] w_a_abs, w_b_abs;
    logic [WIDTH:0]   w_sum, w_rsh;
    logic [WIDTH-1:0] w_mhi, w_mlo, w_diff, w_dhi, w_dlo, w_mul_res, w_div_res;
    logic [2*WIDTH-1:0] w_prod, w_prod_s;
    logic [OP_W-1:0]  w_base, w_op;

    always_comb begin
        w_base = OP_AND;
        case (bus.Funct3)
            3'b000:  w_base = OP_ADD;
            3'b001:  w_base = OP_SLL;
            3'b010:  w_base = OP_SLT;
            3'b011:  w_base = OP_SLTU;
            3'b100:  w_base = OP_XOR;
            3'b101:  w_base = OP_SRL;
            3'b110:  w_base = OP_OR;
            default: w_base = OP_AND;
        endcase
        w_op = OP_AND;
        case (bus.ALUOp)
            2'b00: w_op = OP_ADD;
            2'b01: begin
                case (bus.Funct3)
                    3'b000:  w_op = OP_BEQ;
                    3'b001:  w_op = OP_BNE;
                    3'b100:  w_op = OP_BLT;
                    3'b101:  w_op = OP_BGE;
                    3'b110:  w_op = OP_BLTU;
                    3'b111:  w_op = OP_BGEU;
                    default: w_op = OP_AND;
                endcase
            end
            // M-extension encodings (Funct7=0000001) fall through to 0000
            2'b10: begin
                if (bus.Funct7 == 7'b0000000) begin
                    w_op = w_base;
                end else if (bus.Funct7 == 7'b0100000) begin
                    if (bus.Funct3 == 3'b000)      w_op = OP_SUB;
                    else if (bus.Funct3 == 3'b101) w_op = OP_SRA;
                end
            end
            default: w_op = (bus.Funct3 == 3'b101 && bus.Funct7[5]) ? OP_SRA : w_base;
        endcase
    end

    assign w_is_m   = (bus.ALUOp == 2'b10) && (bus.Funct7 == 7'b0000001);
    assign w_accept = (r_state == S_IDLE) && bus.valid_in && w_is_m && !bus.flush;
    assign w_a_sgn  = bus.Funct3[2] ? ~bus.Funct3[0] : (bus.Funct3[1:0] != 2'b11);
    assign w_b_sgn  = bus.Funct3[2] ? ~bus.Funct3[0] : ~bus.Funct3[1];
    assign w_a_neg  = w_a_sgn & bus.SrcA[WIDTH-1];
    assign w_b_neg  = w_b_sgn & bus.SrcB[WIDTH-1];
    assign w_a_abs  = w_a_neg ? -bus.SrcA : bus.SrcA;
    assign w_b_abs  = w_b_neg ? -bus.SrcB : bus.SrcB;
    assign w_div0   = (bus.SrcB == '0);
    assign w_ovf    = ~bus.Funct3[0] && (bus.SrcA == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.SrcB == '1);

    // Multiply: {r_hi,r_lo} shifts right, r_lo starts as multiplier, r_b is multiplicand
    assign w_sum     = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    assign w_mhi     = w_sum[WIDTH:1];
    assign w_mlo     = {w_sum[0], r_lo[WIDTH-1:1]};
    assign w_prod    = {w_mhi, w_mlo};
    assign w_prod_s  = r_neg_q ? -w_prod : w_prod;
    assign w_mul_res = (r_op == 2'b00) ? w_prod_s[WIDTH-1:0] : w_prod_s[2*WIDTH-1:WIDTH];

    // Divide: r_hi is partial remainder, r_lo shifts dividend out and quotient bits in
    assign w_rsh     = {r_hi, r_lo[WIDTH-1]};
    assign w_ge      = (w_rsh >= {1'b0, r_b});
    assign w_diff    = w_rsh[WIDTH-1:0] - r_b;
    assign w_dhi     = w_ge ? w_diff : w_rsh[WIDTH-1:0];
    assign w_dlo     = {r_lo[WIDTH-2:0], w_ge};
    assign w_div_res = r_op[1] ? (r_neg_r ? -w_dhi : w_dhi) : (r_neg_q ? -w_dlo : w_dlo);

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_hi_n    = r_hi;
        w_lo_n    = r_lo;
        w_b_n     = r_b;
        w_neg_q_n = r_neg_q;
        w_neg_r_n = r_neg_r;
        w_op_n    = r_op;
        w_res_n   = r_result;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_op_n    = bus.Funct3[1:0];
                    w_neg_q_n = w_a_neg ^ w_b_neg;
                    w_neg_r_n = w_a_neg;
                    w_cnt_n   = CNT_W'(WIDTH);
                    w_hi_n    = '0;
                    if (!bus.Funct3[2]) begin
                        w_state_n = S_MUL;
                        w_lo_n    = w_b_abs;
                        w_b_n     = w_a_abs;
                    end else if (w_div0) begin
                        w_state_n = S_DONE;
                        w_res_n   = bus.Funct3[1] ? bus.SrcA : '1;
                    end else if (w_ovf) begin
                        w_state_n = S_DONE;
                        w_res_n   = bus.Funct3[1] ? '0 : bus.SrcA;
                    end else begin
                        w_state_n = S_DIV;
                        w_lo_n    = w_a_abs;
                        w_b_n     = w_b_abs;
                    end
                end
            end
            S_MUL: begin
                w_hi_n  = w_mhi;
                w_lo_n  = w_mlo;
                w_cnt_n = r_cnt - 1'b1;
                if (r_cnt == CNT_W'(1)) begin
                    w_state_n = S_DONE;
                    w_res_n   = w_mul_res;
                end
            end
            S_DIV: begin
                w_hi_n  = w_dhi;
                w_lo_n  = w_dlo;
                w_cnt_n = r_cnt - 1'b1;
                if (r_cnt == CNT_W'(1)) begin
                    w_state_n = S_DONE;
                    w_res_n   = w_div_res;
                end
            end
            default: w_state_n = S_IDLE;
        endcase
        if (bus.flush) begin
            w_state_n = S_IDLE;
            w_res_n   = r_result;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_b      <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_op     <= '0;
            r_result <= '0;
        end else begin
            r_state  <= w_state_n;
            r_cnt    <= w_cnt_n;
            r_hi     <= w_hi_n;
            r_lo     <= w_lo_n;
            r_b      <= w_b_n;
            r_neg_q  <= w_neg_q_n;
            r_neg_r  <= w_neg_r_n;
            r_op     <= w_op_n;
            r_result <= w_res_n;
        end
    end

    assign bus.Operation = w_op;
    assign bus.md_busy   = reset && (w_accept || r_state == S_MUL || r_state == S_DIV);
    assign bus.md_done   = (r_state == S_DONE) && !bus.flush;
    assign bus.md_result = r_result;
endmodule

// File: tb/tb_alu_md_sequencer.sv
// Bench for alu_md_sequencer: decode sweep, directed and random RV32M ops against an arithmetic model.
// Inputs change 2 time units after the rising edge; outputs are sampled 1 unit later.
module tb_alu_md_sequencer;
    localparam int W = 32;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    alu_md_sequencer_if #(.WIDTH(W), .OP_W(4)) bus();
    alu_md_sequencer #(.WIDTH(W), .OP_W(4)) u_dut (.clk(clk), .reset(reset), .bus(bus));

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] last_res = '0;

    logic [3:0] base_tbl [8] = '{4'h2, 4'h3, 4'h8, 4'hD, 4'h6, 4'h4, 4'h7, 4'h0};
    logic [3:0] br_tbl   [8] = '{4'h9, 4'hA, 4'h0, 4'h0, 4'hB, 4'hC, 4'hE, 4'hF};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3,
                         input logic v, input logic fl, input logic [31:0] a, input logic [31:0] b);
        bus.ALUOp = op; bus.Funct7 = f7; bus.Funct3 = f3;
        bus.valid_in = v; bus.flush = fl; bus.SrcA = a; bus.SrcB = b;
    endtask

    function automatic logic [3:0] exp_op(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3);
        if (op == 2'b00) return 4'h2;
        if (op == 2'b01) return br_tbl[f3];
        if (op == 2'b11) return (f3 == 3'b101 && f7[5]) ? 4'h5 : base_tbl[f3];
        if (f7 == 7'h00) return base_tbl[f3];
        if (f7 == 7'h20 && f3 == 3'b000) return 4'h1;
        if (f7 == 7'h20 && f3 == 3'b101) return 4'h5;
        return 4'h0;
    endfunction

    function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint      sa = $signed(a);
        longint      sb = $signed(b);
        longint      ua = {32'b0, a};
        longint      ub = {32'b0, b};
        logic [63:0] p;
        logic        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
        return W + 1;
    endfunction

    task automatic run_md(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int lat = -1;
        int busy_n = 1;
        @(posedge clk); #2;
        drive(2'b10, 7'h01, f3, 1'b1, 1'b0, a, b);
        #1;
        check({tag, " accept busy"}, 32'(bus.md_busy), 32'd1);
        check({tag, " accept done"}, 32'(bus.md_done), 32'd0);
        check({tag, " accept op"}, 32'(bus.Operation), 32'd0);
        check({tag, " result held"}, bus.md_result, last_res);
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); #3;
            if (bus.md_done) begin
                lat = k;
                break;
            end
            if (bus.md_busy) busy_n++;
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        if (lat > 0) begin
            check({tag, " result"}, bus.md_result, exp);
            check({tag, " busy cycles"}, 32'(busy_n), 32'(exp_lat));
            check({tag, " busy in done"}, 32'(bus.md_busy), 32'd0);
        end
        last_res = exp;
    endtask

    task automatic idle_cycle();
        @(posedge clk); #2;
        drive(2'b00, 7'h00, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        check("idle busy", 32'(bus.md_busy), 32'd0);
        check("idle done", 32'(bus.md_done), 32'd0);
    endtask

    initial begin
        logic [6:0]  f7_set [4];
        logic [2:0]  rf3;
        logic [31:0] ra, rb;
        int          n_done;

        // reset state, with an M op presented to show busy is held low
        drive(2'b10, 7'h01, 3'b100, 1'b1, 1'b0, 32'd9, 32'd2);
        #3;
        check("reset busy", 32'(bus.md_busy), 32'd0);
        check("reset done", 32'(bus.md_done), 32'd0);
        check("reset result", bus.md_result, 32'd0);
        @(posedge clk); #2;
        reset = 1'b1;
        drive(2'b00, 7'h00, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        check("post-reset busy", 32'(bus.md_busy), 32'd0);

        // decode sweep
        f7_set = '{7'h00, 7'h20, 7'h01, 7'($urandom_range(0, 127))};
        for (int op = 0; op < 4; op++) begin
            for (int j = 0; j < 4; j++) begin
                for (int f = 0; f < 8; f++) begin
                    @(posedge clk); #2;
                    drive(2'(op), f7_set[j], 3'(f), !(op == 2 && f7_set[j] == 7'h01), 1'b0, 32'h0, 32'h0);
                    #1;
                    check($sformatf("decode op%0d f7=%h f3=%0d", op, f7_set[j], f),
                          32'(bus.Operation), 32'(exp_op(2'(op), f7_set[j], 3'(f))));
                    check("decode no stall", 32'(bus.md_busy), 32'd0);
                end
            end
        end

        // directed arithmetic
        run_md("MUL 7*-3", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        run_md("MULHU max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        run_md("DIV -7/2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        run_md("REM -7/2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        run_md("DIVU 7/0", 3'd5, 32'd7, 32'd0, 32'hFFFF_FFFF, 1);
        run_md("REM ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);
        idle_cycle();

        // flush at cycle 5 of a MUL
        @(posedge clk); #2;
        drive(2'b10, 7'h01, 3'b000, 1'b1, 1'b0, 32'd5, 32'd6);
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #2;
        end
        bus.flush = 1'b1;
        #1;
        check("flush cycle busy", 32'(bus.md_busy), 32'd1);
        @(posedge clk); #2;
        drive(2'b00, 7'h00, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        check("after flush busy", 32'(bus.md_busy), 32'd0);
        n_done = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #3;
            if (bus.md_done) n_done++;
        end
        check("flushed op done count", 32'(n_done), 32'd0);
        run_md("MUL after flush", 3'd0, 32'd123, 32'd456, 32'd56088, 33);

        // back-to-back divides, then with an ADD between them
        run_md("DIV b2b 1", 3'd4, 32'd100, 32'd7, 32'd14, 33);
        run_md("DIV b2b 2", 3'd4, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 33);
        @(posedge clk); #2;
        drive(2'b10, 7'h00, 3'b000, 1'b1, 1'b0, 32'd1, 32'd2);
        #1;
        check("ADD between op", 32'(bus.Operation), 32'h2);
        check("ADD between busy", 32'(bus.md_busy), 32'd0);
        check("ADD between done", 32'(bus.md_done), 32'd0);
        run_md("DIVU after ADD", 3'd5, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 33);

        // randomized M ops against the arithmetic model
        for (int i = 0; i < 16; i++) begin
            rf3 = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'h0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 20));
                default: ;
            endcase
            run_md($sformatf("rand%0d f3=%0d a=%h b=%h", i, rf3, ra, rb), rf3, ra, rb,
                   ref_md(rf3, ra, rb), exp_latency(rf3, ra, rb));
            if ($urandom_range(0, 2) == 0) idle_cycle();
        end

        // async reset in the middle of a DIV
        @(posedge clk); #2;
        drive(2'b10, 7'h01, 3'b100, 1'b1, 1'b0, 32'd1000, 32'd7);
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #2;
        end
        reset = 1'b0;
        #1;
        check("mid-DIV reset busy", 32'(bus.md_busy), 32'd0);
        check("mid-DIV reset done", 32'(bus.md_done), 32'd0);
        check("mid-DIV reset result", bus.md_result, 32'd0);
        @(posedge clk); #2;
        reset = 1'b1;
        drive(2'b00, 7'h00, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        check("release busy", 32'(bus.md_busy), 32'd0);
        last_res = '0;
        run_md("DIV after reset", 3'd4, 32'd1000, 32'd7, 32'd142, 33);
        idle_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
